// File: rtl/radix4_seq_multiplier_pkg.sv
// Shared definitions for the radix-4 sequential multiplier: FSM encodings,
// step count and the operand magnitude helper.
package radix4_seq_multiplier_pkg;

   // Compute cycles per operation: 32 multiplier bits retired 2 per cycle.
   localparam int unsigned P_STEPS = 16;

   typedef enum logic [1:0] {
      L_PARAM_MUL_IDLE = 2'd0,
      L_PARAM_MUL_CALC = 2'd1,
      L_PARAM_MUL_DONE = 2'd2
   } mul_state_t;

   // Magnitude of an operand; -2^31 maps to 0x80000000 read as unsigned.
   function automatic logic [31:0] f_abs32(input logic [31:0] i_v, input logic i_signed);
      return (i_signed && i_v[31]) ? (~i_v + 32'd1) : i_v;
   endfunction

endpackage

// File: rtl/radix4_seq_multiplier_if.sv
// Request/result handshake bundle between the execute stage and the multiplier.
interface radix4_seq_multiplier_if;

   logic        iREQ_VALID;
   logic        oREQ_BUSY;
   logic        iREQ_SIGNED;
   logic [31:0] iREQ_SOURCE0;
   logic [31:0] iREQ_SOURCE1;
   logic        oOUT_VALID;
   logic        iOUT_BUSY;
   logic [63:0] oOUT_DATA;

   // Requester / result consumer side.
   modport master (
      output iREQ_VALID, iREQ_SIGNED, iREQ_SOURCE0, iREQ_SOURCE1, iOUT_BUSY,
      input  oREQ_BUSY, oOUT_VALID, oOUT_DATA
   );

   // Multiplier side.
   modport slave (
      input  iREQ_VALID, iREQ_SIGNED, iREQ_SOURCE0, iREQ_SOURCE1, iOUT_BUSY,
      output oREQ_BUSY, oOUT_VALID, oOUT_DATA
   );

endinterface

// File: rtl/radix4_mul_step.sv
// One radix-4 shift-and-add step. Accumulator layout is
// {partial_sum[33:0], shifting_multiplier[31:0]}; the selected multiple of the
// multiplicand is added into the upper 34 bits, then the pair shifts right 2.
module radix4_mul_step (
   input  logic [65:0] i_acc,
   input  logic [31:0] i_mcand,
   input  logic [33:0] i_mcand3x,
   input  logic [1:0]  i_d,
   output logic [65:0] o_acc
);

   logic [33:0] w_addend;
   logic [33:0] w_sum;
   logic [65:0] w_cat;

   // Select 0, 1x, 2x or 3x multiplicand for the current digit.
   always_comb begin
      w_addend = 34'd0;
      unique case (i_d)
         2'd0: w_addend = 34'd0;
         2'd1: w_addend = {2'b00, i_mcand};
         2'd2: w_addend = {1'b0, i_mcand, 1'b0};
         2'd3: w_addend = i_mcand3x;
      endcase
   end

   // Upper partial sum stays below 2^32 after each shift, so 34 bits cannot carry out.
   always_comb begin
      w_sum = i_acc[65:32] + w_addend;
      w_cat = {w_sum, i_acc[31:0]};
      o_acc = w_cat >> 2;
   end

endmodule

// File: rtl/radix4_seq_multiplier.sv
// Sequential 32x32->64 signed/unsigned multiplier, radix-4 non-Booth.
// Operates on magnitudes and negates the final product for mixed signs.
module radix4_seq_multiplier
   import radix4_seq_multiplier_pkg::*;
(
   input logic                    iCLOCK,
   input logic                    inRESET,
   input logic                    iFLUSH,
   radix4_seq_multiplier_if.slave io_mul
);

   localparam int unsigned L_CNT_W = $clog2(P_STEPS);

   mul_state_t         r_state, w_state;
   logic [L_CNT_W-1:0] r_count, w_count;
   logic [65:0]        r_acc, w_acc;
   logic [31:0]        r_mcand, w_mcand;
   logic [33:0]        r_mcand3x, w_mcand3x;
   logic               r_neg, w_neg;
   logic               r_prep, w_prep;
   logic               r_out_valid, w_out_valid;
   logic [63:0]        r_out_data, w_out_data;
   logic [65:0]        w_step;
   logic [63:0]        w_prod;

   radix4_mul_step u_step (
      .i_acc     (r_acc),
      .i_mcand   (r_mcand),
      .i_mcand3x (r_mcand3x),
      .i_d       (r_acc[1:0]),
      .o_acc     (w_step)
   );

   assign w_prod           = r_neg ? (~w_step[63:0] + 64'd1) : w_step[63:0];
   assign io_mul.oREQ_BUSY  = (r_state != L_PARAM_MUL_IDLE);
   assign io_mul.oOUT_VALID = r_out_valid;
   assign io_mul.oOUT_DATA  = r_out_data;

   // State register.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_state <= L_PARAM_MUL_IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   // Datapath, counter and output registers.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         r_count     <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mcand3x   <= '0;
         r_neg       <= 1'b0;
         r_prep      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_count     <= w_count;
         r_acc       <= w_acc;
         r_mcand     <= w_mcand;
         r_mcand3x   <= w_mcand3x;
         r_neg       <= w_neg;
         r_prep      <= w_prep;
         r_out_valid <= w_out_valid;
         r_out_data  <= w_out_data;
      end
   end

   // Next-state, accept, step sequencing and result capture; flush overrides all.
   always_comb begin
      w_state     = r_state;
      w_count     = r_count;
      w_acc       = r_acc;
      w_mcand     = r_mcand;
      w_mcand3x   = r_mcand3x;
      w_neg       = r_neg;
      w_prep      = r_prep;
      w_out_valid = r_out_valid;
      w_out_data  = r_out_data;

      unique case (r_state)
         L_PARAM_MUL_IDLE: begin
            if (io_mul.iREQ_VALID) begin
               w_mcand = f_abs32(io_mul.iREQ_SOURCE0, io_mul.iREQ_SIGNED);
               w_acc   = {34'd0, f_abs32(io_mul.iREQ_SOURCE1, io_mul.iREQ_SIGNED)};
               w_neg   = io_mul.iREQ_SIGNED &
                         (io_mul.iREQ_SOURCE0[31] ^ io_mul.iREQ_SOURCE1[31]);
               w_count = '0;
               w_prep  = 1'b1;
               w_state = L_PARAM_MUL_CALC;
            end
         end
         L_PARAM_MUL_CALC: begin
            // First CALC cycle registers 3x so the 34-bit adder is off the accept path.
            if (r_prep) begin
               w_mcand3x = {2'b00, r_mcand} + {1'b0, r_mcand, 1'b0};
               w_prep    = 1'b0;
            end else begin
               w_acc   = w_step;
               w_count = r_count + 1'b1;
               if (r_count == L_CNT_W'(P_STEPS - 1)) begin
                  w_state     = L_PARAM_MUL_DONE;
                  w_out_valid = 1'b1;
                  w_out_data  = w_prod;
               end
            end
         end
         L_PARAM_MUL_DONE: begin
            if (!io_mul.iOUT_BUSY) begin
               w_state     = L_PARAM_MUL_IDLE;
               w_out_valid = 1'b0;
            end
         end
         default: begin
            w_state     = L_PARAM_MUL_IDLE;
            w_out_valid = 1'b0;
         end
      endcase

      if (iFLUSH) begin
         w_state     = L_PARAM_MUL_IDLE;
         w_out_valid = 1'b0;
         w_count     = '0;
         w_prep      = 1'b0;
      end
   end

endmodule
